// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, shifter types, NZCV bit positions
// and the 32-bit rotate-right used by the operand shifter.
package exe_stage_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] t;
    t = {x, x} >> amt;
    return t[31:0];
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE register outputs into the execute stage and the results it returns toward EXE/MEM.
interface exe_stage_if #(
  parameter int DW   = 32,
  parameter int SR_W = 4
);
  logic            freeze;
  logic [DW-1:0]   PC_in;
  logic [3:0]      exec_cmd;
  logic            mem_read;
  logic            mem_write;
  logic            S;
  logic            imm;
  logic [DW-1:0]   val_Rn;
  logic [DW-1:0]   val_Rm;
  logic [11:0]     shift_operand;
  logic [23:0]     signed_imm_24;
  logic [DW-1:0]   alu_result;
  logic [DW-1:0]   branch_addr;
  logic [SR_W-1:0] status;

  modport master (
    output freeze, PC_in, exec_cmd, mem_read, mem_write, S, imm,
           val_Rn, val_Rm, shift_operand, signed_imm_24,
    input  alu_result, branch_addr, status
  );

  modport slave (
    input  freeze, PC_in, exec_cmd, mem_read, mem_write, S, imm,
           val_Rn, val_Rm, shift_operand, signed_imm_24,
    output alu_result, branch_addr, status
  );
endinterface

// File: rtl/exe_stage_val2_gen.sv
// Second-operand generator: rotated 8-bit immediate, zero-extended memory offset,
// or Rm through the barrel shifter (LSL/LSR/ASR/ROR).
module exe_stage_val2_gen
  import exe_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          imm,
  input  logic          mem_op,
  input  logic [DW-1:0] val_rm,
  input  logic [11:0]   shift_operand,
  output logic [DW-1:0] val2
);

  logic [4:0]           sh_amt;
  logic [1:0]           sh_type;
  logic signed [DW-1:0] rm_s;

  assign sh_amt  = shift_operand[11:7];
  assign sh_type = shift_operand[6:5];
  assign rm_s    = val_rm;

  // Immediate rotation is always an even amount: twice the 4-bit rotate field.
  always_comb begin
    val2 = val_rm;
    if (imm) begin
      val2 = ror32({24'd0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (mem_op) begin
      val2 = {20'd0, shift_operand};
    end else begin
      case (sh_type)
        SH_LSL:  val2 = val_rm << sh_amt;
        SH_LSR:  val2 = val_rm >> sh_amt;
        SH_ASR:  val2 = rm_s >>> sh_amt;
        SH_ROR:  val2 = ror32(val_rm, sh_amt);
        default: val2 = val_rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand select, Val2 generation, ALU with NZCV flags, branch target adder
// and the registered status word. Define EXE_FORWARDING_EN to add the operand forwarding muxes.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DW   = 32,
  parameter int SR_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  exe_stage_if.slave   bus
`ifdef EXE_FORWARDING_EN
  ,
  input  logic [1:0]    sel_src1,
  input  logic [1:0]    sel_src2,
  input  logic [DW-1:0] mem_fwd_val,
  input  logic [DW-1:0] wb_fwd_val
`endif
);

  logic [DW-1:0]   src1;
  logic [DW-1:0]   src2;
  logic [DW-1:0]   val2;
  logic [DW-1:0]   b_eff;
  logic [DW-1:0]   res;
  logic [DW:0]     sum;
  logic            cin_eff;
  logic            c_in;
  logic            c_nxt;
  logic            v_nxt;
  logic [SR_W-1:0] nzcv_nxt;
  logic [SR_W-1:0] status_p1;

`ifdef EXE_FORWARDING_EN
  // Code 11 is reserved and falls back to the register value.
  function automatic logic [DW-1:0] fwd_mux(input logic [1:0] sel, input logic [DW-1:0] reg_v,
                                            input logic [DW-1:0] mem_v, input logic [DW-1:0] wb_v);
    case (sel)
      2'b01:   return mem_v;
      2'b10:   return wb_v;
      default: return reg_v;
    endcase
  endfunction

  assign src1 = fwd_mux(sel_src1, bus.val_Rn, mem_fwd_val, wb_fwd_val);
  assign src2 = fwd_mux(sel_src2, bus.val_Rm, mem_fwd_val, wb_fwd_val);
`else
  assign src1 = bus.val_Rn;
  assign src2 = bus.val_Rm;
`endif

  assign c_in = status_p1[SR_C];

  exe_stage_val2_gen #(.DW(DW)) u_val2_gen (
    .imm           (bus.imm),
    .mem_op        (bus.mem_read | bus.mem_write),
    .val_rm        (src2),
    .shift_operand (bus.shift_operand),
    .val2          (val2)
  );

  // Subtraction runs as src1 + ~val2 + cin, so bit DW of the sum is NOT borrow directly.
  always_comb begin
    b_eff   = ((bus.exec_cmd == CMD_SUB) || (bus.exec_cmd == CMD_SBC)) ? ~val2 : val2;
    cin_eff = 1'b0;
    case (bus.exec_cmd)
      CMD_ADC, CMD_SBC: cin_eff = c_in;
      CMD_SUB:          cin_eff = 1'b1;
      default:          cin_eff = 1'b0;
    endcase
    sum   = {1'b0, src1} + {1'b0, b_eff} + {{DW{1'b0}}, cin_eff};
    res   = '0;
    c_nxt = status_p1[SR_C];
    v_nxt = status_p1[SR_V];
    case (bus.exec_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        res   = sum[DW-1:0];
        c_nxt = sum[DW];
        v_nxt = (src1[DW-1] == b_eff[DW-1]) && (sum[DW-1] != src1[DW-1]);
      end
      CMD_AND: res = src1 & val2;
      CMD_ORR: res = src1 | val2;
      CMD_EOR: res = src1 ^ val2;
      default: begin
        res   = '0;
        c_nxt = 1'b0;
        v_nxt = 1'b0;
      end
    endcase
    nzcv_nxt       = '0;
    nzcv_nxt[SR_N] = res[DW-1];
    nzcv_nxt[SR_Z] = (res == '0);
    nzcv_nxt[SR_C] = c_nxt;
    nzcv_nxt[SR_V] = v_nxt;
  end

  assign bus.alu_result  = res;
  assign bus.branch_addr = bus.PC_in + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};

  // Stage boundary: status register, visible to the next instruction as its carry-in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_p1 <= '0;
    end else if (bus.S && !bus.freeze) begin
      status_p1 <= nzcv_nxt;
    end
  end

  assign bus.status = status_p1;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed cases plus randomized instructions against an arithmetic model.
// Define EXE_FORWARDING_EN to also exercise the operand forwarding muxes.
module tb_exe_stage;

  localparam longint MAXU = 64'sh0000_0000_FFFF_FFFF;
  localparam longint MAXP = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MINN = -64'sh0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_stage_if #(.DW(32), .SR_W(4)) bus ();

`ifdef EXE_FORWARDING_EN
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] mem_fwd_val;
  logic [31:0] wb_fwd_val;
`endif

  exe_stage #(.DW(32), .SR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef EXE_FORWARDING_EN
    ,
    .sel_src1    (sel_src1),
    .sel_src2    (sel_src2),
    .mem_fwd_val (mem_fwd_val),
    .wb_fwd_val  (wb_fwd_val)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [3:0] m_status;

  // Second operand built bit-by-bit, one single-position shift per step.
  function automatic logic [31:0] ref_val2(input logic im, input logic memop,
                                           input logic [31:0] rm, input logic [11:0] so);
    logic [31:0] x;
    int n;
    if (im) begin
      x = {24'd0, so[7:0]};
      n = 2 * int'(so[11:8]);
      for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
      return x;
    end
    if (memop) return {20'd0, so};
    x = rm;
    n = int'(so[11:7]);
    for (int i = 0; i < n; i++) begin
      case (so[6:5])
        2'd0:    x = {x[30:0], 1'b0};
        2'd1:    x = {1'b0, x[31:1]};
        2'd2:    x = {x[31], x[31:1]};
        default: x = {x[0], x[31:1]};
      endcase
    end
    return x;
  endfunction

  // Flags from exact 64-bit unsigned and signed results rather than carry-out bits.
  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] st, output logic [31:0] r, output logic [3:0] nst);
    longint ua, ub, sa, sb, t, s, k;
    logic c, v;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = st[1];
    v = st[0];
    r = 32'd0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd2, 4'd3: begin
        k = (cmd == 4'd3 && st[1]) ? 64'sd1 : 64'sd0;
        t = ua + ub + k;
        s = sa + sb + k;
        r = t[31:0];
        c = (t > MAXU);
        v = (s > MAXP) || (s < MINN);
      end
      4'd4, 4'd5: begin
        k = (cmd == 4'd5 && !st[1]) ? 64'sd1 : 64'sd0;
        t = ua - ub - k;
        s = sa - sb - k;
        r = t[31:0];
        c = (t >= 64'sd0);
        v = (s > MAXP) || (s < MINN);
      end
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      default: begin
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
      end
    endcase
    nst = {r[31], (r == 32'd0), c, v};
  endfunction

`ifdef EXE_FORWARDING_EN
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'd1) return m;
    if (sel == 2'd2) return w;
    return r;
  endfunction
`endif

  function automatic void predict(output logic [31:0] er, output logic [3:0] ens, output logic [31:0] eb);
    logic [31:0] a, rm;
    int off;
    a  = bus.val_Rn;
    rm = bus.val_Rm;
`ifdef EXE_FORWARDING_EN
    a  = pick(sel_src1, a, mem_fwd_val, wb_fwd_val);
    rm = pick(sel_src2, rm, mem_fwd_val, wb_fwd_val);
`endif
    ref_alu(bus.exec_cmd, a,
            ref_val2(bus.imm, bus.mem_read | bus.mem_write, rm, bus.shift_operand),
            m_status, er, ens);
    off = int'($signed(bus.signed_imm_24));
    eb  = bus.PC_in + 32'(off * 4);
  endfunction

  task automatic set_ops(input logic [3:0] cmd, input logic s, input logic im, input logic mr,
                         input logic mw, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] so, input logic frz);
    bus.exec_cmd      = cmd;
    bus.S             = s;
    bus.imm           = im;
    bus.mem_read      = mr;
    bus.mem_write     = mw;
    bus.val_Rn        = rn;
    bus.val_Rm        = rm;
    bus.shift_operand = so;
    bus.freeze        = frz;
  endtask

  task automatic clk_step(input logic [3:0] ens);
    @(posedge clk);
    if (bus.S && !bus.freeze && rst) m_status = ens;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] er, eb;
    logic [3:0]  ens;
    rst = 1'b1;
    set_ops(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 12'd0, 1'b0);
    bus.PC_in = 32'd0;
    bus.signed_imm_24 = 24'd0;
    m_status = 4'd0;
    #2 rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.status !== 4'b0000) begin bad++; $display("FAIL reset_init got=%b exp=%b", bus.status, 4'b0000); end
    rst = 1'b1;
    set_ops(4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd0, 12'h001, 1'b0);
    #1 predict(er, ens, eb);
    clk_step(ens);
    total++;
    if (bus.status !== 4'b1001) begin bad++; $display("FAIL pre_reset_status got=%b exp=%b", bus.status, 4'b1001); end
    #2 rst = 1'b0;
    m_status = 4'd0;
    #1;
    total++;
    if (bus.status !== 4'b0000) begin bad++; $display("FAIL async_reset got=%b exp=%b", bus.status, 4'b0000); end
    @(posedge clk); #1;
    total++;
    if (bus.status !== 4'b0000) begin bad++; $display("FAIL reset_hold got=%b exp=%b", bus.status, 4'b0000); end
    @(negedge clk);
    rst = 1'b1;
    bus.S = 1'b0;
    #1 predict(er, ens, eb);
    clk_step(ens);
    total++;
    if (bus.status !== 4'b0000) begin bad++; $display("FAIL post_reset_nos got=%b exp=%b", bus.status, 4'b0000); end
  endtask

  task automatic test_directed();
    logic [31:0] er, eb;
    logic [3:0]  ens;
    // ADD overflow into the sign bit
    @(negedge clk);
    set_ops(4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd0, 12'h001, 1'b0);
    #1 predict(er, ens, eb);
    total++;
    if (bus.alu_result !== 32'h8000_0000) begin bad++; $display("FAIL add_ovf_res got=%h exp=%h", bus.alu_result, 32'h8000_0000); end
    clk_step(ens);
    total++;
    if (bus.status !== 4'b1001) begin bad++; $display("FAIL add_ovf_flags got=%b exp=%b", bus.status, 4'b1001); end
    // SUB to zero, then ADC consumes the fresh carry
    @(negedge clk);
    set_ops(4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 12'h005, 1'b0);
    #1 predict(er, ens, eb);
    total++;
    if (bus.alu_result !== 32'd0) begin bad++; $display("FAIL sub_zero_res got=%h exp=%h", bus.alu_result, 32'd0); end
    clk_step(ens);
    total++;
    if (bus.status !== 4'b0110) begin bad++; $display("FAIL sub_zero_flags got=%b exp=%b", bus.status, 4'b0110); end
    @(negedge clk);
    set_ops(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 12'h001, 1'b0);
    #1 predict(er, ens, eb);
    total++;
    if (bus.alu_result !== 32'd3) begin bad++; $display("FAIL adc_carry_res got=%h exp=%h", bus.alu_result, 32'd3); end
    clk_step(ens);
    // immediate rotate and arithmetic shift right
    @(negedge clk);
    set_ops(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 12'h4FF, 1'b0);
    #1;
    total++;
    if (bus.alu_result !== 32'hFF00_0000) begin bad++; $display("FAIL imm_rot got=%h exp=%h", bus.alu_result, 32'hFF00_0000); end
    set_ops(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h8000_0000, {5'd4, 2'b10, 1'b0, 4'd0}, 1'b0);
    #1;
    total++;
    if (bus.alu_result !== 32'hF800_0000) begin bad++; $display("FAIL asr4 got=%h exp=%h", bus.alu_result, 32'hF800_0000); end
    // negative branch offset and frozen status
    bus.PC_in = 32'h100;
    bus.signed_imm_24 = 24'hFFFFFE;
    set_ops(4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 12'h000, 1'b1);
    #1 predict(er, ens, eb);
    total++;
    if (bus.branch_addr !== 32'h0000_00F8) begin bad++; $display("FAIL branch_neg got=%h exp=%h", bus.branch_addr, 32'h0000_00F8); end
    clk_step(ens);
    total++;
    if (bus.status !== 4'b0110) begin bad++; $display("FAIL freeze_hold got=%b exp=%b", bus.status, 4'b0110); end
    // undefined opcode clears C/V and sets Z
    @(negedge clk);
    set_ops(4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 12'h123, 1'b0);
    #1 predict(er, ens, eb);
    total++;
    if (bus.alu_result !== 32'd0) begin bad++; $display("FAIL bad_op_res got=%h exp=%h", bus.alu_result, 32'd0); end
    clk_step(ens);
    total++;
    if (bus.status !== 4'b0100) begin bad++; $display("FAIL bad_op_flags got=%b exp=%b", bus.status, 4'b0100); end
  endtask

  task automatic test_random();
    logic [31:0] er, eb;
    logic [3:0]  ens;
    logic [3:0]  cmd;
    logic        mr, mw;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      mr = 1'b0;
      mw = 1'b0;
      cmd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) begin
        mr = 1'($urandom_range(0, 1));
        mw = !mr;
        cmd = 4'd2;
      end
      set_ops(cmd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mr, mw,
              $urandom, $urandom, 12'($urandom), ($urandom_range(0, 3) == 0));
      bus.PC_in = $urandom;
      bus.signed_imm_24 = 24'($urandom);
`ifdef EXE_FORWARDING_EN
      sel_src1 = 2'($urandom_range(0, 3));
      sel_src2 = 2'($urandom_range(0, 3));
      mem_fwd_val = $urandom;
      wb_fwd_val = $urandom;
`endif
      #1 predict(er, ens, eb);
      total++;
      if (bus.alu_result !== er) begin bad++; $display("FAIL rand_res[%0d] cmd=%h got=%h exp=%h", it, cmd, bus.alu_result, er); end
      total++;
      if (bus.branch_addr !== eb) begin bad++; $display("FAIL rand_branch[%0d] got=%h exp=%h", it, bus.branch_addr, eb); end
      clk_step(ens);
      total++;
      if (bus.status !== m_status) begin bad++; $display("FAIL rand_status[%0d] got=%b exp=%b", it, bus.status, m_status); end
    end
`ifdef EXE_FORWARDING_EN
    sel_src1 = 2'd0;
    sel_src2 = 2'd0;
`endif
  endtask

`ifdef EXE_FORWARDING_EN
  task automatic test_forwarding();
    @(negedge clk);
    sel_src1 = 2'b01;
    sel_src2 = 2'b00;
    mem_fwd_val = 32'd10;
    wb_fwd_val = 32'd77;
    set_ops(4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'd99, 32'd0, 12'h002, 1'b0);
    #1;
    total++;
    if (bus.alu_result !== 32'd12) begin bad++; $display("FAIL fwd_mem_src1 got=%h exp=%h", bus.alu_result, 32'd12); end
    sel_src2 = 2'b10;
    set_ops(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd99, 32'd5, 12'h000, 1'b0);
    #1;
    total++;
    if (bus.alu_result !== 32'd77) begin bad++; $display("FAIL fwd_wb_src2 got=%h exp=%h", bus.alu_result, 32'd77); end
    sel_src2 = 2'b11;
    #1;
    total++;
    if (bus.alu_result !== 32'd5) begin bad++; $display("FAIL fwd_reserved got=%h exp=%h", bus.alu_result, 32'd5); end
    sel_src1 = 2'b00;
    sel_src2 = 2'b00;
  endtask
`endif

  initial begin
`ifdef EXE_FORWARDING_EN
    sel_src1 = 2'd0;
    sel_src2 = 2'd0;
    mem_fwd_val = 32'd0;
    wb_fwd_val = 32'd0;
`endif
    test_reset();
    test_directed();
`ifdef EXE_FORWARDING_EN
    test_forwarding();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
